flexka_buffer_ram_r4w1: RTL and testbench

FLEXKA_BUFFER_RAM_R4W1 -- requirements
Module: flexka_buffer_ram_r4w1

---
 rtl/flexka_buffer_ram_r4w1_if.sv | 50 +++++
 rtl/flexka_buffer_ram_r4w1.sv | 163 ++++++++++++++++
 tb/tb_flexka_buffer_ram_r4w1.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/flexka_buffer_ram_r4w1_if.sv
// -----------------------------------------------------------------------------
// flexka_buffer_ram_r4w1_if
// Bundles the request/response signals of the 4-read / 1-write buffer RAM.
//   read_valid          : read request this cycle
//   raddr0..raddr3      : four independent read addresses
//   waddr, wdata, wren  : external write port
//   init_start          : request to zero the whole array
//   rdata0..rdata3      : read data, LAT cycles after the matching raddrN
//   rdata_valid         : read_valid delayed by LAT cycles
//   init_busy           : zero-sweep in progress
//   init_done           : one-cycle pulse when the sweep completes
//   wr_drop_err         : sticky, an external write was dropped during a sweep
// master = requester side, slave = RAM side.
// -----------------------------------------------------------------------------
interface flexka_buffer_ram_r4w1_if #(
   parameter int FSIZE = 32,
   parameter int AW    = 6
);
   logic             read_valid;
   logic [AW-1:0]    raddr0;
   logic [AW-1:0]    raddr1;
   logic [AW-1:0]    raddr2;
   logic [AW-1:0]    raddr3;
   logic [AW-1:0]    waddr;
   logic [FSIZE-1:0] wdata;
   logic             wren;
   logic             init_start;
   logic [FSIZE-1:0] rdata0;
   logic [FSIZE-1:0] rdata1;
   logic [FSIZE-1:0] rdata2;
   logic [FSIZE-1:0] rdata3;
   logic             rdata_valid;
   logic             init_busy;
   logic             init_done;
   logic             wr_drop_err;

   modport master (
      output read_valid, raddr0, raddr1, raddr2, raddr3,
      output waddr, wdata, wren, init_start,
      input  rdata0, rdata1, rdata2, rdata3,
      input  rdata_valid, init_busy, init_done, wr_drop_err
   );

   modport slave (
      input  read_valid, raddr0, raddr1, raddr2, raddr3,
      input  waddr, wdata, wren, init_start,
      output rdata0, rdata1, rdata2, rdata3,
      output rdata_valid, init_busy, init_done, wr_drop_err
   );
endinterface

// File: rtl/flexka_buffer_ram_r4w1.sv
// -----------------------------------------------------------------------------
// flexka_buffer_ram_r4w1
// DEPTH x FSIZE buffer RAM with one write port and four read ports.
// Reads sample the array (write-first) and emerge after a LAT-stage register
// pipeline. An init_start request sweeps zeros through the whole array, one
// word per cycle, while external writes are dropped and flagged.
// Ports:
//   clk   : clock, rising edge
//   rstn  : synchronous active-low reset (control and read pipeline only;
//           array contents are preserved)
//   bus   : flexka_buffer_ram_r4w1_if.slave, all request/response signals
// -----------------------------------------------------------------------------
module flexka_buffer_ram_r4w1 #(
   parameter int FSIZE = 32,
   parameter int DEPTH = 64,
   parameter int LAT   = 2
) (
   input logic                      clk,
   input logic                      rstn,
   flexka_buffer_ram_r4w1_if.slave  bus
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } state_t;

   state_t           state_q;
   state_t           state_nxt;
   logic [AW-1:0]    cnt_q;
   logic [AW-1:0]    cnt_nxt;
   logic             done_q;
   logic             done_nxt;
   logic             drop_err_q;

   // Effective write for this cycle: either the external port or the sweep.
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [FSIZE-1:0] wr_data;

   logic [FSIZE-1:0] mem [DEPTH];

   logic [AW-1:0]    raddr [4];
   logic [FSIZE-1:0] rd_p0 [4];
   // rd_pn[s] / vld_pn[s] hold pipeline stage p(s+1).
   logic [FSIZE-1:0] rd_pn [LAT][4];
   logic [LAT-1:0]   vld_pn;

   // ---------------------------------------------------------------------------
   // Sweep FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         done_q     <= 1'b0;
         drop_err_q <= 1'b0;
      end else begin
         state_q    <= state_nxt;
         cnt_q      <= cnt_nxt;
         done_q     <= done_nxt;
         // A write arriving while the sweep owns the port is lost.
         drop_err_q <= drop_err_q | (bus.wren && (state_q == SWEEP));
      end
   end

   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      done_nxt  = 1'b0;
      wr_en     = 1'b0;
      wr_addr   = bus.waddr;
      wr_data   = bus.wdata;
      case (state_q)
         IDLE: begin
            // The external write in the init_start cycle still lands.
            wr_en = bus.wren;
            if (bus.init_start) begin
               state_nxt = SWEEP;
               cnt_nxt   = '0;
            end
         end
         SWEEP: begin
            // Reset aborts the sweep, so the word under the counter is not
            // touched on the reset edge.
            wr_en   = rstn;
            wr_addr = cnt_q;
            wr_data = '0;
            cnt_nxt = cnt_q + AW'(1);
            if (cnt_q == AW'(DEPTH - 1)) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Storage (never reset)
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // ---------------------------------------------------------------------------
   // Stage p0: write-first sample of the array for each read port
   // ---------------------------------------------------------------------------
   assign raddr[0] = bus.raddr0;
   assign raddr[1] = bus.raddr1;
   assign raddr[2] = bus.raddr2;
   assign raddr[3] = bus.raddr3;

   always_comb begin
      for (int k = 0; k < 4; k++) begin
         rd_p0[k] = mem[raddr[k]];
         if (wr_en && (wr_addr == raddr[k])) begin
            rd_p0[k] = wr_data;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stages p1..pLAT: free-running read pipeline, valid travels alongside
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int s = 0; s < LAT; s++) begin
            for (int k = 0; k < 4; k++) begin
               rd_pn[s][k] <= '0;
            end
         end
         vld_pn <= '0;
      end else begin
         for (int k = 0; k < 4; k++) begin
            rd_pn[0][k] <= rd_p0[k];
         end
         vld_pn[0] <= bus.read_valid;
         for (int s = 1; s < LAT; s++) begin
            for (int k = 0; k < 4; k++) begin
               rd_pn[s][k] <= rd_pn[s-1][k];
            end
            vld_pn[s] <= vld_pn[s-1];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign bus.rdata0      = rd_pn[LAT-1][0];
   assign bus.rdata1      = rd_pn[LAT-1][1];
   assign bus.rdata2      = rd_pn[LAT-1][2];
   assign bus.rdata3      = rd_pn[LAT-1][3];
   assign bus.rdata_valid = vld_pn[LAT-1];
   assign bus.init_busy   = (state_q == SWEEP);
   assign bus.init_done   = done_q;
   assign bus.wr_drop_err = drop_err_q;

endmodule

// File: tb/tb_flexka_buffer_ram_r4w1.sv
// -----------------------------------------------------------------------------
// tb_flexka_buffer_ram_r4w1
// Directed self-checking bench for flexka_buffer_ram_r4w1 (FSIZE=32,
// DEPTH=64, LAT=2). Inputs change 1 time unit after a rising edge and
// outputs are sampled at that same point, so each step() moves one cycle.
// -----------------------------------------------------------------------------
module tb_flexka_buffer_ram_r4w1;
   localparam int FSIZE = 32;
   localparam int DEPTH = 64;
   localparam int AW    = 6;
   localparam int LAT   = 2;

   logic clk;
   logic rstn;
   int   n_chk;
   int   n_fail;

   logic [FSIZE-1:0] rd [4];
   logic             rv;

   flexka_buffer_ram_r4w1_if #(.FSIZE(FSIZE), .AW(AW)) bus ();

   flexka_buffer_ram_r4w1 #(.FSIZE(FSIZE), .DEPTH(DEPTH), .LAT(LAT)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h expected=%h", tag, act, exp);
      end
   endtask

   function automatic logic [FSIZE-1:0] pat(input int a);
      return 32'h5A5A_0000 + 32'(a) + 32'd1;
   endfunction

   task automatic wr(input logic [AW-1:0] a, input logic [FSIZE-1:0] d);
      bus.wren  = 1'b1;
      bus.waddr = a;
      bus.wdata = d;
      step();
      bus.wren  = 1'b0;
   endtask

   // Issue one read on all four ports and collect the result LAT cycles later.
   task automatic rd4(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                      input logic [AW-1:0] a2, input logic [AW-1:0] a3);
      bus.raddr0     = a0;
      bus.raddr1     = a1;
      bus.raddr2     = a2;
      bus.raddr3     = a3;
      bus.read_valid = 1'b1;
      step();
      bus.read_valid = 1'b0;
      repeat (LAT - 1) step();
      rv    = bus.rdata_valid;
      rd[0] = bus.rdata0;
      rd[1] = bus.rdata1;
      rd[2] = bus.rdata2;
      rd[3] = bus.rdata3;
   endtask

   task automatic preload_all();
      for (int a = 0; a < DEPTH; a++) begin
         wr(AW'(a), pat(a));
      end
   endtask

   initial begin
      logic seen_done;
      logic seen_vld;
      int   addr;

      n_chk  = 0;
      n_fail = 0;
      rstn   = 1'b0;
      bus.read_valid = 1'b0;
      bus.raddr0     = '0;
      bus.raddr1     = '0;
      bus.raddr2     = '0;
      bus.raddr3     = '0;
      bus.waddr      = '0;
      bus.wdata      = '0;
      bus.wren       = 1'b0;
      bus.init_start = 1'b0;
      repeat (3) step();

      // Reset state
      chk("rst_rdata_valid", bus.rdata_valid, 0);
      chk("rst_init_busy",   bus.init_busy,   0);
      chk("rst_init_done",   bus.init_done,   0);
      chk("rst_wr_drop_err", bus.wr_drop_err, 0);
      chk("rst_rdata0",      bus.rdata0,      0);
      chk("rst_rdata3",      bus.rdata3,      0);
      rstn = 1'b1;
      step();

      // Write 0xDEADBEEF@5 in cycle 0, read 5,5,6,5 in cycle 1, result in cycle 3
      wr(6, 32'h6666_6666);
      bus.wren  = 1'b1;
      bus.waddr = 5;
      bus.wdata = 32'hDEAD_BEEF;
      step();
      bus.wren       = 1'b0;
      bus.read_valid = 1'b1;
      bus.raddr0     = 5;
      bus.raddr1     = 5;
      bus.raddr2     = 6;
      bus.raddr3     = 5;
      step();
      bus.read_valid = 1'b0;
      chk("basic_vld_c2", bus.rdata_valid, 0);
      step();
      chk("basic_vld_c3", bus.rdata_valid, 1);
      chk("basic_rdata0", bus.rdata0, 32'hDEAD_BEEF);
      chk("basic_rdata1", bus.rdata1, 32'hDEAD_BEEF);
      chk("basic_rdata2", bus.rdata2, 32'h6666_6666);
      chk("basic_rdata3", bus.rdata3, 32'hDEAD_BEEF);
      step();
      chk("basic_vld_c4", bus.rdata_valid, 0);

      // Same-cycle write and read of address 9: write-first
      wr(9, 32'h1111_1111);
      bus.wren       = 1'b1;
      bus.waddr      = 9;
      bus.wdata      = 32'h1234_5678;
      bus.read_valid = 1'b1;
      bus.raddr0     = 9;
      bus.raddr2     = 9;
      bus.raddr1     = 6;
      step();
      bus.wren       = 1'b0;
      bus.read_valid = 1'b0;
      step();
      chk("wfirst_vld",    bus.rdata_valid, 1);
      chk("wfirst_rdata2", bus.rdata2, 32'h1234_5678);
      chk("wfirst_rdata0", bus.rdata0, 32'h1234_5678);
      chk("wfirst_rdata1", bus.rdata1, 32'h6666_6666);

      // Read 9 at t, write 9 at t+1: sampled data is the old value
      bus.read_valid = 1'b1;
      bus.raddr0     = 9;
      step();
      bus.read_valid = 1'b0;
      bus.wren       = 1'b1;
      bus.waddr      = 9;
      bus.wdata      = 32'hAAAA_5555;
      step();
      bus.wren = 1'b0;
      chk("late_wr_vld",    bus.rdata_valid, 1);
      chk("late_wr_rdata0", bus.rdata0, 32'h1234_5678);
      rd4(9, 9, 9, 9);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("late_wr_new%0d", k), rd[k], 32'hAAAA_5555);
      end

      // Preload, then zero-sweep with a dropped write, an ignored init_start
      // and reads racing the sweep
      preload_all();
      rd4(0, 21, 42, 63);
      chk("pre_vld", rv, 1);
      chk("pre_0",  rd[0], pat(0));
      chk("pre_21", rd[1], pat(21));
      chk("pre_42", rd[2], pat(42));
      chk("pre_63", rd[3], pat(63));

      bus.init_start = 1'b1;
      step();
      bus.init_start = 1'b0;
      for (int c = 1; c <= DEPTH; c++) begin
         chk($sformatf("sweep_busy_c%0d", c), bus.init_busy, 1);
         chk($sformatf("sweep_done_c%0d", c), bus.init_done, 0);
         if (c == 9)  chk("drop_err_before", bus.wr_drop_err, 0);
         if (c == 11) chk("drop_err_set",    bus.wr_drop_err, 1);
         if (c == 42) begin
            chk("race_vld",    bus.rdata_valid, 1);
            chk("race_ahead",  bus.rdata0, pat(50));
            chk("race_wfirst", bus.rdata1, 0);
         end
         bus.wren       = (c == 10);
         bus.waddr      = 3;
         bus.wdata      = 32'hFFFF_FFFF;
         bus.init_start = (c == 30);
         bus.read_valid = (c == 40);
         bus.raddr0     = 50;
         bus.raddr1     = 39;
         step();
      end
      bus.wren       = 1'b0;
      bus.init_start = 1'b0;
      bus.read_valid = 1'b0;
      chk("sweep_end_busy", bus.init_busy, 0);
      chk("sweep_end_done", bus.init_done, 1);

      // init_start in the init_done cycle starts a fresh sweep
      bus.init_start = 1'b1;
      step();
      bus.init_start = 1'b0;
      chk("restart_done_low", bus.init_done, 0);
      chk("restart_busy",     bus.init_busy, 1);
      repeat (DEPTH - 1) step();
      chk("restart_last_busy", bus.init_busy, 1);
      chk("restart_last_done", bus.init_done, 0);
      step();
      chk("restart_end_busy", bus.init_busy, 0);
      chk("restart_end_done", bus.init_done, 1);
      step();
      chk("restart_done_pulse", bus.init_done, 0);

      for (int a = 0; a < DEPTH; a += 4) begin
         rd4(AW'(a), AW'(a + 1), AW'(a + 2), AW'(a + 3));
         chk($sformatf("zero_vld_%0d", a), rv, 1);
         for (int k = 0; k < 4; k++) begin
            chk($sformatf("zero_%0d", a + k), rd[k], 0);
         end
      end
      chk("drop_err_sticky", bus.wr_drop_err, 1);
      rstn = 1'b0;
      step();
      rstn = 1'b1;
      chk("drop_err_cleared", bus.wr_drop_err, 0);
      step();

      // Reset in sweep cycle 20 aborts it
      preload_all();
      bus.init_start = 1'b1;
      step();
      bus.init_start = 1'b0;
      repeat (18) step();
      chk("abort_busy_c19", bus.init_busy, 1);
      bus.read_valid = 1'b1;
      bus.raddr0     = 40;
      step();
      rstn = 1'b0;
      step();
      rstn           = 1'b1;
      bus.read_valid = 1'b0;
      chk("abort_busy", bus.init_busy, 0);
      chk("abort_vld",  bus.rdata_valid, 0);
      seen_done = 1'b0;
      seen_vld  = 1'b0;
      for (int c = 0; c < 70; c++) begin
         seen_done = seen_done | bus.init_done;
         seen_vld  = seen_vld | bus.rdata_valid;
         step();
      end
      chk("abort_no_done", seen_done, 0);
      chk("abort_no_vld",  seen_vld, 0);
      for (int a = 0; a < DEPTH; a += 4) begin
         rd4(AW'(a), AW'(a + 1), AW'(a + 2), AW'(a + 3));
         for (int k = 0; k < 4; k++) begin
            addr = a + k;
            if (addr <= 18) chk($sformatf("abort_zero_%0d", addr), rd[k], 0);
            else if (addr >= 20) chk($sformatf("abort_keep_%0d", addr), rd[k], pat(addr));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
